// File: rtl/video_pkg.sv
// Shared types for the video pattern generator: pattern selector, FSM states, default counter width.
package video_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 11;

  typedef enum logic [1:0] {
    HGRAD   = 2'd0,
    VGRAD   = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } pattern_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

endpackage

// File: rtl/video_timing_cntr.sv
// Pixel-period / x / y counters with registered de/hs/vs strobes; held cleared while run is low.
module video_timing_cntr #(
  parameter int unsigned CNT_WIDTH = video_pkg::CNT_WIDTH_DEF,
  parameter int unsigned PER_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [PER_WIDTH-1:0] p_m1,
  input  logic [CNT_WIDTH-1:0] l_m1,
  input  logic [CNT_WIDTH-1:0] f_m1,
  output logic [CNT_WIDTH-1:0] x,
  output logic [CNT_WIDTH-1:0] y,
  output logic                 tick,
  output logic                 frame_end,
  output logic                 de,
  output logic                 hs,
  output logic                 vs
);

  logic [PER_WIDTH-1:0] pc;
  logic                 line_end;

  // tick marks the cycle whose edge emits pixel (x,y)
  assign tick      = run && (pc == p_m1);
  assign line_end  = (x == l_m1);
  assign frame_end = tick && line_end && (y == f_m1);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      pc <= '0;
      x  <= '0;
      y  <= '0;
      de <= 1'b0;
      hs <= 1'b0;
      vs <= 1'b0;
    end else begin
      de <= tick;
      hs <= tick && line_end;
      vs <= frame_end;
      if (tick) begin
        pc <= '0;
        if (line_end) begin
          x <= '0;
          y <= (y == f_m1) ? '0 : y + CNT_WIDTH'(1);
        end else begin
          x <= x + CNT_WIDTH'(1);
        end
      end else begin
        pc <= pc + PER_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: FSM, per-frame config shadow registers and pattern mux.
// Optional VIDEO_PATTERN_GEN_FRAME_CNT_EN adds frame_cnt_o and scrolling gradients.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH   = video_pkg::CNT_WIDTH_DEF,
  parameter int unsigned PER_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [PER_WIDTH-1:0]   pixel_period_i,
  input  logic [CNT_WIDTH-1:0]   line_pixels_i,
  input  logic [CNT_WIDTH-1:0]   frame_lines_i,
  input  logic [1:0]             pattern_i,
  input  logic [3:0]             cell_log2_i,
  input  logic [PIXEL_WIDTH-1:0] solid_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_cnt_o
`endif
);

  gen_state_t             state, next_state;
  logic                   latch;
  logic [PER_WIDTH-1:0]   p_m1;
  logic [CNT_WIDTH-1:0]   l_m1, f_m1;
  pattern_t               pat_q;
  logic [3:0]             cell_q;
  logic [PIXEL_WIDTH-1:0] solid_q;
  logic [CNT_WIDTH-1:0]   x, y;
  logic                   tick, frame_end;
  logic [PIXEL_WIDTH-1:0] pix_val, scroll;
  logic [CNT_WIDTH-1:0]   chk;

  video_timing_cntr #(
    .CNT_WIDTH (CNT_WIDTH),
    .PER_WIDTH (PER_WIDTH)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .run       (state == RUN),
    .p_m1      (p_m1),
    .l_m1      (l_m1),
    .f_m1      (f_m1),
    .x         (x),
    .y         (y),
    .tick      (tick),
    .frame_end (frame_end),
    .de        (de_o),
    .hs        (hs_o),
    .vs        (vs_o)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    latch      = 1'b0;
    unique case (state)
      IDLE: begin
        if (en_i) begin
          latch      = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (frame_end) begin
          latch      = 1'b1;
          next_state = en_i ? RUN : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Limits are stored as value-1 (zero clamped to one) so the counters compare directly
  always_ff @(posedge clk) begin
    if (rst) begin
      p_m1    <= '0;
      l_m1    <= '0;
      f_m1    <= '0;
      pat_q   <= HGRAD;
      cell_q  <= '0;
      solid_q <= '0;
    end else if (latch) begin
      p_m1    <= (pixel_period_i == '0) ? '0 : pixel_period_i - PER_WIDTH'(1);
      l_m1    <= (line_pixels_i  == '0) ? '0 : line_pixels_i  - CNT_WIDTH'(1);
      f_m1    <= (frame_lines_i  == '0) ? '0 : frame_lines_i  - CNT_WIDTH'(1);
      pat_q   <= pattern_t'(pattern_i);
      cell_q  <= cell_log2_i;
      solid_q <= solid_i;
    end
  end

`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
  // Counts on the edge that raises vs_o, so the next frame's first pixel already scrolls
  always_ff @(posedge clk) begin
    if (rst)            frame_cnt_o <= '0;
    else if (frame_end) frame_cnt_o <= frame_cnt_o + 16'd1;
  end
  assign scroll = PIXEL_WIDTH'(frame_cnt_o);
`else
  assign scroll = '0;
`endif

  assign chk = (x ^ y) >> cell_q;

  always_comb begin
    pix_val = '0;
    unique case (pat_q)
      HGRAD:   pix_val = PIXEL_WIDTH'(x) + scroll;
      VGRAD:   pix_val = PIXEL_WIDTH'(y) + scroll;
      CHECKER: pix_val = chk[0] ? '1 : '0;
      SOLID:   pix_val = solid_q;
      default: pix_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       do_o <= '0;
    else if (tick) do_o <= pix_val;
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: stimulus pushes expected pixels, negedge monitor checks them.
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic [7:0]  pixel_period_i;
  logic [10:0] line_pixels_i;
  logic [10:0] frame_lines_i;
  logic [1:0]  pattern_i;
  logic [3:0]  cell_log2_i;
  logic [7:0]  solid_i;
  logic [7:0]  do_o;
  logic        de_o, hs_o, vs_o;
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
`endif

  video_pattern_gen #(
    .PIXEL_WIDTH (8),
    .CNT_WIDTH   (11),
    .PER_WIDTH   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en_i),
    .pixel_period_i (pixel_period_i),
    .line_pixels_i  (line_pixels_i),
    .frame_lines_i  (frame_lines_i),
    .pattern_i      (pattern_i),
    .cell_log2_i    (cell_log2_i),
    .solid_i        (solid_i),
    .do_o           (do_o),
    .de_o           (de_o),
    .hs_o           (hs_o),
    .vs_o           (vs_o)
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
    ,
    .frame_cnt_o    (frame_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t   q[$];
  exp_t   e_mon;
  int     errors = 0;
  int     checks = 0;
  int     vs_cnt = 0;
  int     pops = 0;
  longint cyc = 0;
  longint prev_cyc = 0;
  longint first_exp = -1;
  bit     have_prev = 0;
  int     exp_period = 1;
  int     exp_fc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (de_o) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_de: got do=%h hs=%b vs=%b, required no pixel", do_o, hs_o, vs_o);
        end else begin
          e_mon = q.pop_front();
          if ({do_o, hs_o, vs_o} !== e_mon) begin
            errors++;
            $display("FAIL pixel#%0d: got do=%h hs=%b vs=%b, required do=%h hs=%b vs=%b",
                     pops, do_o, hs_o, vs_o, e_mon.d, e_mon.hs, e_mon.vs);
          end
          pops++;
        end
        if (first_exp >= 0) begin
          checks++;
          if (cyc != first_exp) begin
            errors++;
            $display("FAIL first_de_latency: got cycle %0d, required %0d", cyc, first_exp);
          end
          first_exp = -1;
        end
        if (have_prev) begin
          checks++;
          if (cyc - prev_cyc != longint'(exp_period)) begin
            errors++;
            $display("FAIL de_spacing: got %0d clk, required %0d", cyc - prev_cyc, exp_period);
          end
        end
        have_prev = 1;
        prev_cyc  = cyc;
        if (vs_o) vs_cnt++;
      end else if (hs_o || vs_o) begin
        checks++;
        errors++;
        $display("FAIL strobe_without_de: got hs=%b vs=%b, required 0 when de=0", hs_o, vs_o);
      end
    end
  end

  function automatic logic [7:0] model(int x, int y, logic [1:0] pat, int c, logic [7:0] s, int fc);
    case (pat)
      2'd0:    return 8'(x + fc);
      2'd1:    return 8'(y + fc);
      2'd2:    return ((((x >> c) ^ (y >> c)) & 1) != 0) ? 8'hFF : 8'h00;
      default: return s;
    endcase
  endfunction

  task automatic push_frame(int l, int f, logic [1:0] pat, int c, logic [7:0] s);
    int le = (l == 0) ? 1 : l;
    int fe = (f == 0) ? 1 : f;
    for (int yy = 0; yy < fe; yy++)
      for (int xx = 0; xx < le; xx++)
        q.push_back({model(xx, yy, pat, c, s, exp_fc), xx == le - 1, (xx == le - 1) && (yy == fe - 1)});
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
    exp_fc++;
`endif
  endtask

  task automatic wait_vs(int target, int limit, string name);
    int t = 0;
    while (vs_cnt < target && t < limit) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (vs_cnt < target) begin
      errors++;
      $display("FAIL timeout_%s: got %0d vs pulses, required %0d", name, vs_cnt, target);
    end
  endtask

  task automatic idle_and_drain(int pe, string name);
    repeat (2 * pe + 4) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_%s: got %0d pixels missing, required 0", name, q.size());
    end
    q.delete();
  endtask

  // Runs n frames; config is scrambled and en_i dropped during the last frame
  task automatic run_frames(int p, int l, int f, logic [1:0] pat, int c, logic [7:0] s, int n, string name);
    int pe    = (p == 0) ? 1 : p;
    int le    = (l == 0) ? 1 : l;
    int fe    = (f == 0) ? 1 : f;
    int limit = pe * le * fe + 20;
    int start = vs_cnt;
    pixel_period_i = 8'(p);
    line_pixels_i  = 11'(l);
    frame_lines_i  = 11'(f);
    pattern_i      = pat;
    cell_log2_i    = 4'(c);
    solid_i        = s;
    exp_period     = pe;
    have_prev      = 0;
    for (int k = 0; k < n; k++) push_frame(l, f, pat, c, s);
    en_i = 1'b1;
    @(negedge clk); #1;
    first_exp = cyc + longint'(pe);
    wait_vs(start + n - 1, limit * n, name);
    en_i           = 1'b0;
    line_pixels_i  = 11'(l + 3);
    frame_lines_i  = 11'(f + 1);
    pattern_i      = pat + 2'd1;
    solid_i        = ~s;
    pixel_period_i = 8'(p + 1);
    wait_vs(start + n, limit, name);
    idle_and_drain(pe, name);
  endtask

  initial begin
    int start;
    int t;
    rst            = 1'b1;
    en_i           = 1'b0;
    pixel_period_i = 8'd1;
    line_pixels_i  = 11'd4;
    frame_lines_i  = 11'd3;
    pattern_i      = 2'd0;
    cell_log2_i    = 4'd0;
    solid_i        = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({do_o, de_o, hs_o, vs_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got do=%h de=%b hs=%b vs=%b, required all 0", do_o, de_o, hs_o, vs_o);
    end
    #1 rst = 1'b0;

    run_frames(1, 4, 3, 2'd0, 0, 8'h00, 2, "hgrad_p1");
    run_frames(6, 5, 3, 2'd1, 0, 8'h00, 2, "vgrad_p6");
    run_frames(1, 1, 260, 2'd1, 0, 8'h00, 1, "vgrad_wrap");
    run_frames(1, 260, 1, 2'd0, 0, 8'h00, 1, "hgrad_wrap");
    run_frames(1, 8, 4, 2'd2, 1, 8'h00, 1, "checker_c1");
    run_frames(3, 3, 2, 2'd3, 0, 8'hA5, 1, "solid");
    run_frames(0, 0, 0, 2'd0, 0, 8'h00, 3, "zero_cfg");
    // frame launched at L=4 completes at L=4 although run_frames rewrites L mid-frame
    run_frames(2, 4, 2, 2'd0, 0, 8'h00, 1, "lchange_l4");
    run_frames(2, 8, 2, 2'd0, 0, 8'h00, 1, "lchange_l8");

    // reset mid-line
    pixel_period_i = 8'd3;
    line_pixels_i  = 11'd4;
    frame_lines_i  = 11'd3;
    pattern_i      = 2'd0;
    exp_period     = 3;
    have_prev      = 0;
    start          = pops;
    push_frame(4, 3, 2'd0, 0, 8'h00);
    en_i = 1'b1;
    @(negedge clk); #1;
    first_exp = cyc + 3;
    t = 0;
    while (pops < start + 3 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (pops < start + 3) begin
      errors++;
      $display("FAIL timeout_pre_reset: got %0d pixels, required %0d", pops - start, 3);
    end
    rst = 1'b1;
    q.delete();
    exp_fc = 0;
    @(negedge clk);
    checks++;
    if ({do_o, de_o, hs_o, vs_o} !== 11'd0) begin
      errors++;
      $display("FAIL midline_reset: got do=%h de=%b hs=%b vs=%b, required all 0", do_o, de_o, hs_o, vs_o);
    end
    #1 rst = 1'b0;
    have_prev = 0;
    start     = vs_cnt;
    push_frame(4, 3, 2'd0, 0, 8'h00);
    @(negedge clk); #1;
    first_exp = cyc + 3;
    en_i      = 1'b0;
    wait_vs(start + 1, 60, "after_reset");
    idle_and_drain(3, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
